// File: rtl/airi5c_fpu_result_queue_pkg.sv
// Shared FPU definitions used by the result queue: entry record layout,
// fflags bit positions and the canonical quiet NaN.
package airi5c_fpu_result_queue_pkg;

    localparam int          ENTRY_W        = 38;
    localparam int          FFLAGS_NV_BIT  = 4;
    localparam logic [31:0] CANONICAL_QNAN = 32'h7fc00000;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        iv;
    } entry_t;

endpackage

// File: rtl/airi5c_fpu_result_queue.sv
// Circular result buffer between the FPU min/max selector and the FP register
// file write port, with sticky NV accumulation at retirement and kill flush.
module airi5c_fpu_result_queue
    import airi5c_fpu_result_queue_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       kill,
    input  logic                       in_valid,
    input  logic [31:0]                in_data,
    input  logic                       in_iv,
    input  logic [4:0]                 in_rd,
    output logic                       can_accept,
    output logic                       wb_valid,
    input  logic                       wb_ready,
    output logic [31:0]                wb_data,
    output logic [4:0]                 wb_rd,
    output logic                       wb_iv,
    output logic                       nv_sticky,
    input  logic                       nv_clr,
    output logic                       overflow,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    entry_t             mem [DEPTH];
    entry_t             in_entry;
    entry_t             head;

    logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic               nv_reg, nv_next;
    logic               ovf_reg, ovf_next;

    logic               full, empty, pop, push, push_eff, pop_eff;

    assign full     = (count_reg == CNT_W'(DEPTH));
    assign empty    = (count_reg == '0);
    assign pop      = !empty && wb_ready;
    assign push     = in_valid && (!full || pop);
    // A kill squashes whatever handshake happens in the same cycle.
    assign push_eff = push && !kill;
    assign pop_eff  = pop && !kill;

    assign in_entry = '{data: in_data, rd: in_rd, iv: in_iv};
    assign head     = mem[rd_ptr_reg];

    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        nv_next     = nv_reg;
        ovf_next    = ovf_reg;

        if (kill) begin
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push_eff) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
            if (pop_eff)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
            if (push_eff && !pop_eff)
                count_next = count_reg + CNT_W'(1);
            else if (pop_eff && !push_eff)
                count_next = count_reg - CNT_W'(1);
        end

        // NV is raised only when an entry retires, so squashed results never flag.
        if (nv_clr)                nv_next = 1'b0;
        if (pop_eff && head.iv)    nv_next = 1'b1;

        if (in_valid && full && !pop) ovf_next = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            nv_reg     <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
            nv_reg     <= nv_next;
            ovf_reg    <= ovf_next;
        end
    end

    // Storage needs no reset: the head is masked whenever the queue is empty.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (push_eff && (wr_ptr_reg == PTR_W'(gi)))
                mem[gi] <= in_entry;
        end
    end

    assign wb_valid   = !empty;
    assign wb_data    = wb_valid ? head.data : 32'd0;
    assign wb_rd      = wb_valid ? head.rd   : 5'd0;
    assign wb_iv      = wb_valid && head.iv;
    assign can_accept = !full || wb_ready;
    assign nv_sticky  = nv_reg;
    assign overflow   = ovf_reg;
    assign count      = count_reg;

endmodule

// File: tb/tb_airi5c_fpu_result_queue.sv
// Directed vector bench for the FPU result queue (DEPTH=2): a table of
// per-cycle inputs and expected pre-edge outputs, plus an async reset sequence.
`timescale 1ns/1ps
module tb_airi5c_fpu_result_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        kill;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_iv;
    logic [4:0]  in_rd;
    logic        can_accept;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_iv;
    logic        nv_sticky;
    logic        nv_clr;
    logic        overflow;
    logic [1:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    airi5c_fpu_result_queue #(.DEPTH(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .kill       (kill),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_iv      (in_iv),
        .in_rd      (in_rd),
        .can_accept (can_accept),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_data    (wb_data),
        .wb_rd      (wb_rd),
        .wb_iv      (wb_iv),
        .nv_sticky  (nv_sticky),
        .nv_clr     (nv_clr),
        .overflow   (overflow),
        .count      (count)
    );

    typedef struct {
        logic        kill;
        logic        in_valid;
        logic [31:0] in_data;
        logic        in_iv;
        logic [4:0]  in_rd;
        logic        wb_ready;
        logic        nv_clr;
        logic        e_wbv;
        logic [31:0] e_data;
        logic [4:0]  e_rd;
        logic        e_iv;
        logic [1:0]  e_cnt;
        logic        e_ca;
        logic        e_nv;
        logic        e_ov;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic k, input logic v, input logic [31:0] d, input logic iv,
                       input logic [4:0] rd, input logic rdy, input logic clr,
                       input logic e_wbv, input logic [31:0] e_data, input logic [4:0] e_rd,
                       input logic e_iv, input logic [1:0] e_cnt, input logic e_ca,
                       input logic e_nv, input logic e_ov);
        vec_t t;
        t = '{k, v, d, iv, rd, rdy, clr, e_wbv, e_data, e_rd, e_iv, e_cnt, e_ca, e_nv, e_ov};
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input vec_t t);
        check({tag, " wb_valid"},   32'(wb_valid),   32'(t.e_wbv));
        check({tag, " wb_data"},    wb_data,         t.e_data);
        check({tag, " wb_rd"},      32'(wb_rd),      32'(t.e_rd));
        check({tag, " wb_iv"},      32'(wb_iv),      32'(t.e_iv));
        check({tag, " count"},      32'(count),      32'(t.e_cnt));
        check({tag, " can_accept"}, 32'(can_accept), 32'(t.e_ca));
        check({tag, " nv_sticky"},  32'(nv_sticky),  32'(t.e_nv));
        check({tag, " overflow"},   32'(overflow),   32'(t.e_ov));
    endtask

    task automatic idle_inputs();
        kill = 0; in_valid = 0; in_data = 0; in_iv = 0; in_rd = 0; wb_ready = 0; nv_clr = 0;
    endtask

    localparam logic [31:0] QN = 32'h7fc00000;

    initial begin
        vec_t rst_exp;
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_exp = '{0, 0, 0, 0, 0, 0, 0, 0, 32'd0, 5'd0, 0, 2'd0, 1, 0, 0};
        check_all("reset", rst_exp);
        reset = 1'b0;

        //   k  v  data          iv rd  rdy clr | wbv data          rd  iv cnt ca nv ov
        // basic push / one-cycle latency / pop
        add(0, 0, 0,            0, 0,  0, 0,   0, 0,            0,  0, 0, 1, 0, 0);
        add(0, 1, 32'h3f800000, 0, 5,  1, 0,   0, 0,            0,  0, 0, 1, 0, 0);
        add(0, 0, 0,            0, 0,  1, 0,   1, 32'h3f800000, 5,  0, 1, 1, 0, 0);
        add(0, 0, 0,            0, 0,  0, 0,   0, 0,            0,  0, 0, 1, 0, 0);
        // full push+pop across pointer wrap
        add(0, 1, 32'h40a00000, 0, 4,  0, 0,   0, 0,            0,  0, 0, 1, 0, 0);
        add(0, 1, 32'h40c00000, 0, 6,  0, 0,   1, 32'h40a00000, 4,  0, 1, 1, 0, 0);
        add(0, 1, 32'h40e00000, 0, 7,  1, 0,   1, 32'h40a00000, 4,  0, 2, 1, 0, 0);
        add(0, 1, 32'h41000000, 0, 8,  1, 0,   1, 32'h40c00000, 6,  0, 2, 1, 0, 0);
        add(0, 0, 0,            0, 0,  1, 0,   1, 32'h40e00000, 7,  0, 2, 1, 0, 0);
        add(0, 0, 0,            0, 0,  1, 0,   1, 32'h41000000, 8,  0, 1, 1, 0, 0);
        add(0, 0, 0,            0, 0,  0, 0,   0, 0,            0,  0, 0, 1, 0, 0);
        // back-pressure, dropped third push, stable head, ordered drain
        add(0, 1, 32'h40000000, 0, 1,  0, 0,   0, 0,            0,  0, 0, 1, 0, 0);
        add(0, 1, 32'h40400000, 0, 2,  0, 0,   1, 32'h40000000, 1,  0, 1, 1, 0, 0);
        add(0, 1, 32'h40800000, 0, 3,  0, 0,   1, 32'h40000000, 1,  0, 2, 0, 0, 0);
        add(0, 0, 0,            0, 0,  0, 0,   1, 32'h40000000, 1,  0, 2, 0, 0, 1);
        add(0, 0, 0,            0, 0,  1, 0,   1, 32'h40000000, 1,  0, 2, 1, 0, 1);
        add(0, 0, 0,            0, 0,  1, 0,   1, 32'h40400000, 2,  0, 1, 1, 0, 1);
        add(0, 0, 0,            0, 0,  0, 0,   0, 0,            0,  0, 0, 1, 0, 1);
        // NV raised after pop; clear coinciding with setting pop loses
        add(0, 1, QN,           1, 9,  0, 0,   0, 0,            0,  0, 0, 1, 0, 1);
        add(0, 0, 0,            0, 0,  1, 0,   1, QN,           9,  1, 1, 1, 0, 1);
        add(0, 1, QN,           1, 10, 0, 0,   0, 0,            0,  0, 0, 1, 1, 1);
        add(0, 0, 0,            0, 0,  1, 1,   1, QN,           10, 1, 1, 1, 1, 1);
        add(0, 0, 0,            0, 0,  0, 0,   0, 0,            0,  0, 0, 1, 1, 1);
        add(0, 0, 0,            0, 0,  0, 1,   0, 0,            0,  0, 0, 1, 1, 1);
        add(0, 0, 0,            0, 0,  0, 0,   0, 0,            0,  0, 0, 1, 0, 1);
        // kill flushes an iv entry without raising NV; push during kill ignored
        add(0, 1, QN,           1, 11, 0, 0,   0, 0,            0,  0, 0, 1, 0, 1);
        add(1, 0, 0,            0, 0,  0, 0,   1, QN,           11, 1, 1, 1, 0, 1);
        add(0, 0, 0,            0, 0,  1, 0,   0, 0,            0,  0, 0, 1, 0, 1);
        add(1, 1, 32'h3f800000, 0, 12, 1, 0,   0, 0,            0,  0, 0, 1, 0, 1);
        add(0, 0, 0,            0, 0,  1, 0,   0, 0,            0,  0, 0, 1, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            kill     = vecs[i].kill;
            in_valid = vecs[i].in_valid;
            in_data  = vecs[i].in_data;
            in_iv    = vecs[i].in_iv;
            in_rd    = vecs[i].in_rd;
            wb_ready = vecs[i].wb_ready;
            nv_clr   = vecs[i].nv_clr;
            #1;
            check_all($sformatf("vec%0d", i), vecs[i]);
            $display("vec%0d k=%0b v=%0b d=%08h rdy=%0b -> wbv=%0b d=%08h rd=%0d cnt=%0d nv=%0b ov=%0b",
                     i, kill, in_valid, in_data, wb_ready, wb_valid, wb_data, wb_rd, count,
                     nv_sticky, overflow);
        end

        // Async reset between edges with a full queue
        @(negedge clk);
        idle_inputs();
        in_valid = 1; in_data = 32'h42000000; in_rd = 13; in_iv = 1;
        @(negedge clk);
        in_data = 32'h42100000; in_rd = 14;
        @(negedge clk);
        idle_inputs();
        #1;
        check("pre-reset count", 32'(count), 32'd2);
        check("pre-reset wb_data", wb_data, 32'h42000000);
        #2;
        reset = 1'b1;
        #1;
        check("async wb_valid",   32'(wb_valid),   32'd0);
        check("async count",      32'(count),      32'd0);
        check("async wb_data",    wb_data,         32'd0);
        check("async wb_rd",      32'(wb_rd),      32'd0);
        check("async wb_iv",      32'(wb_iv),      32'd0);
        check("async can_accept", 32'(can_accept), 32'd1);
        check("async overflow",   32'(overflow),   32'd0);
        check("async nv_sticky",  32'(nv_sticky),  32'd0);
        $display("async reset: wbv=%0b cnt=%0d ca=%0b ov=%0b", wb_valid, count, can_accept, overflow);
        wb_ready = 1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        check("post-reset count",  32'(count),     32'd0);
        check("post-reset nv",     32'(nv_sticky), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
